// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST front-end blocks.
// State encodings stay plain localparams so legacy RTL can compare against them directly.
package fast_pkg;

    localparam int unsigned COORD_W         = 10;
    localparam int unsigned PIXEL_WIDTH_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StSync   = 3'd1;
    localparam state_t StPrst   = 3'd2;
    localparam state_t StStream = 3'd3;
    localparam state_t StFlush  = 3'd4;
    localparam state_t StDone   = 3'd5;

endpackage

// File: rtl/fast_stream_ctrl_if.sv
// Valid/ready pixel stream from the DMA, with start-of-frame (tuser) and end-of-line (tlast).
// master drives pixels (DMA side), slave accepts them (frame sequencer).
interface fast_stream_ctrl_if import fast_pkg::*; #(
    parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF
) ();

    logic [PIXEL_WIDTH-1:0] s_pixel;
    logic                   s_valid;
    logic                   s_sof;
    logic                   s_eol;
    logic                   s_ready;

    modport master (
        output s_pixel,
        output s_valid,
        output s_sof,
        output s_eol,
        input  s_ready
    );

    modport slave (
        input  s_pixel,
        input  s_valid,
        input  s_sof,
        input  s_eol,
        output s_ready
    );

endinterface

// File: rtl/fast_line_cnt.sv
// Column/row raster counter: advances on en, wraps at the frame edges, clr has priority.
// col_last flags the final column of a line, last flags the final pixel of the frame.
module fast_line_cnt import fast_pkg::*; #(
    parameter int unsigned COL_NUM = 640,
    parameter int unsigned ROW_NUM = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               col_last,
    output logic               last
);

    localparam logic [COORD_W-1:0] ColMax = COORD_W'(COL_NUM - 1);
    localparam logic [COORD_W-1:0] RowMax = COORD_W'(ROW_NUM - 1);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               row_last;

    assign col_last = (col_q == ColMax);
    assign row_last = (row_q == RowMax);
    assign last     = col_last && row_last;
    assign col      = col_q;
    assign row      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/fast_stream_ctrl.sv
// Frame sequencer for the FAST 7x7 window generator: SOF alignment, enable gating and flush.
// Define FAST_STREAM_STATS_EN to add the frame_cnt / stall_cnt statistics outputs.
module fast_stream_ctrl import fast_pkg::*; #(
    parameter int unsigned COL_NUM     = 640,
    parameter int unsigned ROW_NUM     = 480,
    parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int unsigned PRST_CYCLES = 2,
    parameter int unsigned FLUSH_LEN   = 3 * COL_NUM + 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    fast_stream_ctrl_if.slave      dma,
    input  logic                   ds_ready,
    output logic                   pipe_ce,
    output logic                   pipe_rst,
    output logic [PIXEL_WIDTH-1:0] pipe_data,
    output logic [COORD_W-1:0]     col,
    output logic [COORD_W-1:0]     row,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_line_len,
    output logic                   err_sof,
    input  logic                   err_clr
`ifdef FAST_STREAM_STATS_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned PrstW  = (PRST_CYCLES > 1) ? $clog2(PRST_CYCLES) : 1;
    localparam int unsigned FlushW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    state_t              state_q, state_d;
    logic [PrstW-1:0]    prst_q, prst_d;
    logic [FlushW-1:0]   flush_q, flush_d;
    logic                frame_done_q, frame_done_d;
    logic                err_line_q, err_line_d;
    logic                err_sof_q, err_sof_d;

    logic beat;
    logic ready;
    logic cnt_en, cnt_clr;
    logic col_last, last_pix;
    logic line_err, sof_err;

    fast_line_cnt #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM)
    ) u_line_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .last     (last_pix)
    );

    // An aborting cycle never consumes a pixel or clocks the generator.
    assign beat = (state_q == StStream) && dma.s_valid && ds_ready && !abort;

    always_comb begin
        ready     = 1'b0;
        pipe_ce   = 1'b0;
        pipe_rst  = 1'b0;
        pipe_data = '0;
        case (state_q)
            StIdle:   pipe_rst = 1'b1;
            // Pre-SOF beats are swallowed; the SOF beat itself is held for PRST.
            StSync:   ready = dma.s_valid && !dma.s_sof && !abort;
            StPrst:   pipe_rst = 1'b1;
            StStream: begin
                ready     = ds_ready && !abort;
                pipe_ce   = beat;
                pipe_data = dma.s_pixel;
            end
            StFlush:  pipe_ce = ds_ready && !abort;
            default:  ;
        endcase
    end

    assign dma.s_ready = ready;
    assign busy        = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        prst_d   = prst_q;
        flush_d  = flush_q;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        line_err = 1'b0;
        sof_err  = 1'b0;
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                StIdle: if (start) state_d = StSync;
                StSync: begin
                    if (dma.s_valid && dma.s_sof) begin
                        state_d = StPrst;
                        prst_d  = PrstW'(PRST_CYCLES - 1);
                    end
                end
                StPrst: begin
                    cnt_clr = 1'b1;
                    if (prst_q == '0) state_d = StStream;
                    else              prst_d  = prst_q - 1'b1;
                end
                StStream: begin
                    if (beat) begin
                        cnt_en   = 1'b1;
                        line_err = (dma.s_eol != col_last);
                        sof_err  = dma.s_sof && ((col | row) != '0);
                        // The counter wraps itself back to (0,0) on the last pixel.
                        if (last_pix) begin
                            state_d = StFlush;
                            flush_d = FlushW'(FLUSH_LEN - 1);
                        end
                    end
                end
                StFlush: begin
                    if (ds_ready) begin
                        if (flush_q == '0) state_d = StDone;
                        else               flush_d = flush_q - 1'b1;
                    end
                end
                StDone:  state_d = start ? StSync : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign frame_done_d = (state_q == StDone) && !abort;
    assign err_line_d   = line_err ? 1'b1 : (err_clr ? 1'b0 : err_line_q);
    assign err_sof_d    = sof_err  ? 1'b1 : (err_clr ? 1'b0 : err_sof_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prst_q       <= '0;
            flush_q      <= '0;
            frame_done_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prst_q       <= prst_d;
            flush_q      <= flush_d;
            frame_done_q <= frame_done_d;
            err_line_q   <= err_line_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign frame_done   = frame_done_q;
    assign err_line_len = err_line_q;
    assign err_sof      = err_sof_q;

`ifdef FAST_STREAM_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (frame_done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
            if ((state_q != StPrst) && (state_d == StPrst)) begin
                stall_cnt_q <= '0;
            end else if ((state_q == StStream) && dma.s_valid && !ds_ready &&
                         (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fast_stream_ctrl.sv
// Self-checking bench for fast_stream_ctrl on an 8x4 frame; pipe output is scoreboarded.
module tb_fast_stream_ctrl;

    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 4;
    localparam int unsigned PW   = 8;
    localparam int unsigned PRST = 2;
    localparam int unsigned FLEN = 5;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [9:0]    col;
        logic [9:0]    row;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ds_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic          pipe_ce, pipe_rst, busy, frame_done, err_line_len, err_sof;
    logic [PW-1:0] pipe_data;
    logic [9:0]    col, row;
`ifdef FAST_STREAM_STATS_EN
    logic [15:0]   frame_cnt;
    logic [31:0]   stall_cnt;
`endif

    int   checks = 0;
    int   failures = 0;
    int   ce_count = 0;
    exp_t sb[$];

    fast_stream_ctrl_if #(.PIXEL_WIDTH(PW)) sif ();

    fast_stream_ctrl #(
        .COL_NUM     (COLS),
        .ROW_NUM     (ROWS),
        .PIXEL_WIDTH (PW),
        .PRST_CYCLES (PRST),
        .FLUSH_LEN   (FLEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .dma          (sif.slave),
        .ds_ready     (ds_ready),
        .pipe_ce      (pipe_ce),
        .pipe_rst     (pipe_rst),
        .pipe_data    (pipe_data),
        .col          (col),
        .row          (row),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_line_len (err_line_len),
        .err_sof      (err_sof),
        .err_clr      (err_clr)
`ifdef FAST_STREAM_STATS_EN
        ,
        .frame_cnt    (frame_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Every generator enable must match the oldest expected pixel (data and coordinate).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pipe_ce) begin
            ce_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pipe_beat: unexpected pipe_ce, data=%0h, scoreboard empty", pipe_data);
            end else begin
                e = sb.pop_front();
                if (pipe_data !== e.data || col !== e.col || row !== e.row) begin
                    failures++;
                    $display("FAIL pipe_beat: got data=%0h col=%0d row=%0d, expected data=%0h col=%0d row=%0d",
                             pipe_data, col, row, e.data, e.col, e.row);
                end
            end
        end
    end

    task automatic drive_beat(input logic [PW-1:0] pix, input logic sof, input logic eol,
                              output int prst_seen, output logic ce_acc);
        bit got = 1'b0;
        prst_seen   = 0;
        ce_acc      = 1'b0;
        sif.s_pixel = pix;
        sif.s_sof   = sof;
        sif.s_eol   = eol;
        sif.s_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (busy && pipe_rst) prst_seen++;
            if (sif.s_ready) begin
                got    = 1'b1;
                ce_acc = pipe_ce;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: s_ready=0 for 50 cycles, expected a handshake");
        end
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        sif.s_eol   = 1'b0;
    endtask

    task automatic send_frame(input int n_pre, input int stall_idx, input int eol_bad,
                              input int sof_bad, input bit flush_stall, input int abort_at,
                              input logic [7:0] seed, output int prst_seen, output int done_cyc);
        int   ps;
        logic ce_acc;
        logic [9:0] c, r;
        logic [PW-1:0] pix;
        ce_count  = 0;
        prst_seen = 0;
        for (int j = 0; j < n_pre; j++) begin
            drive_beat(8'hA0 + 8'(j), 1'b0, 1'b0, ps, ce_acc);
            checks++;
            if (ce_acc !== 1'b0) begin
                failures++;
                $display("FAIL pre_sof_drop: beat %0d pipe_ce=%b, expected 0", j, ce_acc);
            end
        end
        for (int i = 0; i < int'(COLS * ROWS); i++) begin
            c   = 10'(i % COLS);
            r   = 10'(i / COLS);
            pix = 8'(i * 13) + seed;
            sb.push_back('{data: pix, col: c, row: r});
            if (i == stall_idx) begin
                sif.s_pixel = pix;
                sif.s_sof   = 1'b0;
                sif.s_eol   = 1'b0;
                sif.s_valid = 1'b1;
                ds_ready    = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checks++;
                    if (sif.s_ready !== 1'b0 || pipe_ce !== 1'b0 || col !== c || row !== r) begin
                        failures++;
                        $display("FAIL stall_hold: s_ready=%b pipe_ce=%b col=%0d row=%0d, expected 0 0 %0d %0d",
                                 sif.s_ready, pipe_ce, col, row, c, r);
                    end
                    @(posedge clk);
                    #1;
                end
                ds_ready = 1'b1;
            end
            drive_beat(pix, (i == 0) || (i == sof_bad), (c == 10'(COLS - 1)) || (i == eol_bad),
                       ps, ce_acc);
            if (i == 0) prst_seen = ps;
        end
        for (int k = 0; k < int'(FLEN); k++) sb.push_back('{data: '0, col: '0, row: '0});
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            ds_ready = !(flush_stall && cyc >= 2 && cyc <= 5);
            abort    = (cyc == abort_at);
            if (abort) start = 1'b0;
            @(negedge clk);
            if (abort_at != 0 && cyc == abort_at + 1) begin
                checks++;
                if (busy !== 1'b0 || pipe_rst !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_idle: busy=%b pipe_rst=%b, expected 0 1", busy, pipe_rst);
                end
            end
            if (frame_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        abort    = 1'b0;
        ds_ready = 1'b1;
        if (done_cyc != 0) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse: frame_done=%b one cycle later, expected 0", frame_done);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        sif.s_eol   = 1'b0;
        sif.s_pixel = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pipe_rst, sif.s_ready, pipe_ce, busy, frame_done} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: rst/rdy/ce/busy/done=%b, expected 10000",
                     {pipe_rst, sif.s_ready, pipe_ce, busy, frame_done});
        end
        checks++;
        if (col !== 10'd0 || row !== 10'd0 || pipe_data !== '0) begin
            failures++;
            $display("FAIL reset_data: col=%0d row=%0d data=%0h, expected 0 0 0", col, row, pipe_data);
        end
        checks++;
        if (err_line_len !== 1'b0 || err_sof !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: err_line_len=%b err_sof=%b, expected 0 0", err_line_len, err_sof);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pipe_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle_hold: busy=%b pipe_rst=%b with start=0, expected 0 1", busy, pipe_rst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int prst, input int done,
                               input int exp_done);
        checks++;
        if (prst !== int'(PRST)) begin
            failures++;
            $display("FAIL %s_prst: pipe_rst cycles=%0d, expected %0d", name, prst, PRST);
        end
        checks++;
        if (ce_count !== int'(COLS * ROWS + FLEN)) begin
            failures++;
            $display("FAIL %s_ce_count: got %0d, expected %0d", name, ce_count, COLS * ROWS + FLEN);
        end
        checks++;
        if (done !== exp_done) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d, expected %0d", name, done, exp_done);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL %s_leftover: %0d expected beats not seen, expected 0", name, sb.size());
        end
    endtask

    task automatic test_frame();
        int prst, done;
        start = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, -1, -1, -1, 1'b0, 0, 8'h10, prst, done);
        check_frame("frame", prst, done, 7);
        checks++;
        if (err_line_len !== 1'b0 || err_sof !== 1'b0) begin
            failures++;
            $display("FAIL frame_err: err_line_len=%b err_sof=%b, expected 0 0", err_line_len, err_sof);
        end
    endtask

    task automatic test_pre_sof();
        int prst, done;
        send_frame(3, -1, -1, -1, 1'b0, 0, 8'h33, prst, done);
        check_frame("pre_sof", prst, done, 7);
    endtask

    task automatic test_stall();
        int prst, done;
        send_frame(0, 11, -1, -1, 1'b1, 0, 8'h5A, prst, done);
        check_frame("stall", prst, done, 11);
`ifdef FAST_STREAM_STATS_EN
        checks++;
        if (stall_cnt !== 32'd4) begin
            failures++;
            $display("FAIL stall_cnt: got %0d, expected 4", stall_cnt);
        end
`endif
    endtask

    task automatic test_errors();
        int prst, done;
        send_frame(0, -1, 21, 9, 1'b0, 0, 8'h77, prst, done);
        check_frame("errors", prst, done, 7);
        checks++;
        if (err_line_len !== 1'b1 || err_sof !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err_line_len=%b err_sof=%b, expected 1 1", err_line_len, err_sof);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (err_line_len !== 1'b0 || err_sof !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: err_line_len=%b err_sof=%b, expected 0 0", err_line_len, err_sof);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int prst, done;
        int seen = 0;
        send_frame(0, -1, -1, -1, 1'b0, 3, 8'h99, prst, done);
        sb.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen++;
        end
        checks++;
        if (done !== 0 || seen !== 0) begin
            failures++;
            $display("FAIL abort_no_done: frame_done seen at cycle %0d (+%0d later), expected none",
                     done, seen);
        end
        checks++;
        if (busy !== 1'b0 || col !== 10'd0 || row !== 10'd0) begin
            failures++;
            $display("FAIL abort_state: busy=%b col=%0d row=%0d, expected 0 0 0", busy, col, row);
        end
`ifdef FAST_STREAM_STATS_EN
        checks++;
        if (frame_cnt !== 16'd4) begin
            failures++;
            $display("FAIL frame_cnt: got %0d, expected 4", frame_cnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pre_sof();
        test_stall();
        test_errors();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
